wavetable_loader: RTL and testbench
===================================

// Module: wavetable_loader
// PURPOSE
// - Writer side of the oscillator wavetable: receives a byte stream (valid/ready), packs little-endian
//   16-bit samples, writes them into the inactive bank of a 2-bank sample RAM.
// - Oscillators read the active bank.
// - Swaps banks only after a complete frame with a good checksum, so a reader never sees a half-loaded table.
// PARAMETERS
// - DATA_W     16      sample width; must be 16 (two bytes per sample)
// - ADDR_W     10      log2 table depth (DEPTH = 1024 samples per bank)
// - SYNC_BYTE  8'hA5   frame start marker
// PORTS
// - clk          in   1         single clock, rising edge
// - reset        in   1         asynchronous, active-high
// - in_byte      in   8         stream byte
// - in_valid     in   1         in_byte valid
// - in_ready     out  1         loader accepts; transfer = in_valid & in_ready
// - abort        in   1         discard current frame
// - wr_en        out  1         RAM write strobe (1 cycle)
// - wr_addr      out  ADDR_W+1  {bank, index}; bank is always ~active_bank
// - wr_data      out  DATA_W    sample {hi_byte, lo_byte}
// - active_bank  out  1         bank oscillators read
// - busy         out  1         frame in progress (state != HUNT)
// - done         out  1         1-cycle pulse on successful swap
// - csum_err     out  1         1-cycle pulse on checksum mismatch
// BEHAVIOUR
// - Reset (async): state=HUNT, in_ready=1, wr_en=0, wr_addr=0, wr_data=0, active_bank=0, busy=0,
//   done=0, csum_err=0, index=0, csum=0.
// - Frame: SYNC_BYTE, then 2*DEPTH data bytes (lo, hi per sample, index 0..DEPTH-1), then 1 checksum byte.
// - Checksum = XOR of all 2*DEPTH data bytes.
// - States:
//   - HUNT: in_ready=1; non-sync bytes dropped; sync -> DATA_LO, index=0, csum=0.
//   - DATA_LO: latch lo byte, csum^=byte -> DATA_HI.
//   - DATA_HI: on accept, csum^=byte; next cycle wr_en=1, wr_addr={~active_bank,index},
//     wr_data={byte,lo} (write latency 1 cycle after hi byte).
//     - index==DEPTH-1 -> CSUM, else index+1 and -> DATA_LO.
//   - CSUM: on accept compare byte with csum -> COMMIT.
//   - COMMIT: in_ready=0 for exactly 1 cycle.
//     - Match: active_bank toggles, done=1.
//     - Mismatch: csum_err=1, bank unchanged.
//     - Then -> HUNT.
// - in_ready=1 in every state except COMMIT. Stalls (in_valid=0) hold all state; no timeout.
// - Sync value inside the data region is data, not a restart.
// - abort: highest priority, any state. Next edge -> HUNT, index=0, csum=0, no done/err.
//   A byte offered in the same cycle is consumed and discarded.
//   wr_en already pending from the previous cycle still completes.
//   Aborting in COMMIT suppresses swap, done and err.
// - Index arithmetic is ADDR_W-bit; the last sample is detected by compare, never by wrap.
// - Active bank is never written. Partial or aborted frames leave only inactive-bank contents modified.
// - Back-to-back frames allowed: the first sync can arrive the cycle after COMMIT.
// STRUCTURE
// - Shared package synth_pkg: state enum typedef (HUNT, DATA_LO, DATA_HI, CSUM, COMMIT),
//   SYNC_BYTE and DEPTH constants shared with the oscillator.
// - One natural sub-module: wavetable_bank_ram
//   - 2*DEPTH x DATA_W; write port from this block, read port {active_bank, index} for the oscillator.
//   - Instantiated at the top, not inside this loader.
// TESTING
// - Reset mid-frame (after 100 samples) -> all outputs at reset values, active_bank=0,
//   next full frame loads bank 1.
// - Full frame, sample i = i*3, correct checksum, in_valid always 1
//   -> 1024 writes to addr 1024+i, done pulse, active_bank 0->1, in_ready low one cycle.
// - Same frame, checksum byte XOR 8'h01 -> csum_err pulse, active_bank unchanged, no done.
// - Second good frame after a swap -> writes target addr 0..1023, active_bank 1->0.
// - Random in_valid gaps (~30% idle) plus leading junk bytes 8'h00, 8'h5A before sync
//   -> same RAM contents and done as a gapless run.
// - abort asserted during sample 500 hi byte -> HUNT next cycle, no swap.
//   Following good frame fully loads and swaps.

Source files
------------

// File: rtl/synth_pkg.sv
// Constants and loader state encoding shared by the wavetable loader, its bank RAM and the oscillators.
package synth_pkg;

  localparam int unsigned WT_DATA_W    = 16;
  localparam int unsigned WT_ADDR_W    = 10;
  localparam int unsigned WT_DEPTH     = 1 << WT_ADDR_W;
  localparam logic [7:0]  WT_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    HUNT,
    DATA_LO,
    DATA_HI,
    CSUM,
    COMMIT
  } loader_state_e;

endpackage

// File: rtl/wavetable_bank_ram.sv
// Two-bank sample RAM: write port from the loader, synchronous read port for the oscillators.
module wavetable_bank_ram
  import synth_pkg::*;
#(
  parameter int unsigned DATA_W = WT_DATA_W,
  parameter int unsigned ADDR_W = WT_ADDR_W
) (
  input  logic              clk_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W:0]   wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W:0]   rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int unsigned WORDS = 2 << ADDR_W;

  logic [DATA_W-1:0] mem_q [WORDS];

  // Read returns the old word on a same-address collision.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
    rd_data_o <= mem_q[rd_addr_i];
  end

endmodule

// File: rtl/wavetable_loader.sv
// Loads a sync-framed byte stream into the inactive wavetable bank and swaps banks
// only after a complete frame whose XOR checksum matches.
module wavetable_loader
  import synth_pkg::*;
#(
  parameter int unsigned DATA_W    = WT_DATA_W,
  parameter int unsigned ADDR_W    = WT_ADDR_W,
  parameter logic [7:0]  SYNC_BYTE = WT_SYNC_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic              wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              active_bank,
  output logic              busy,
  output logic              done,
  output logic              csum_err
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  loader_state_e state_q, state_d;

  logic [ADDR_W-1:0] index_q, index_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        lo_q, lo_d;
  logic              csum_ok_q, csum_ok_d;
  logic              active_q, active_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic xfer, is_sync, is_last;

  assign xfer    = in_valid & in_ready_q;
  assign is_sync = (in_byte == SYNC_BYTE);
  assign is_last = (index_q == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort overrides every state; COMMIT always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = HUNT;
    end else begin
      case (state_q)
        HUNT:    if (xfer && is_sync) state_d = DATA_LO;
        DATA_LO: if (xfer) state_d = DATA_HI;
        DATA_HI: if (xfer) state_d = is_last ? CSUM : DATA_LO;
        CSUM:    if (xfer) state_d = COMMIT;
        COMMIT:  state_d = HUNT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    index_d    = index_q;
    csum_d     = csum_q;
    lo_d       = lo_q;
    csum_ok_d  = csum_ok_q;
    active_d   = active_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    in_ready_d = (state_d != COMMIT);
    busy_d     = (state_d != HUNT);
    if (abort) begin
      index_d = '0;
      csum_d  = '0;
    end else begin
      case (state_q)
        HUNT: begin
          if (xfer && is_sync) begin
            index_d = '0;
            csum_d  = '0;
          end
        end
        DATA_LO: begin
          if (xfer) begin
            lo_d   = in_byte;
            csum_d = csum_q ^ in_byte;
          end
        end
        DATA_HI: begin
          if (xfer) begin
            csum_d    = csum_q ^ in_byte;
            wr_en_d   = 1'b1;
            wr_addr_d = {~active_q, index_q};
            wr_data_d = DATA_W'({in_byte, lo_q});
            if (!is_last) index_d = index_q + 1'b1;
          end
        end
        CSUM: begin
          if (xfer) csum_ok_d = (in_byte == csum_q);
        end
        COMMIT: begin
          if (csum_ok_q) begin
            active_d = ~active_q;
            done_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_q    <= '0;
      csum_q     <= '0;
      lo_q       <= '0;
      csum_ok_q  <= 1'b0;
      active_q   <= 1'b0;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      index_q    <= index_d;
      csum_q     <= csum_d;
      lo_q       <= lo_d;
      csum_ok_q  <= csum_ok_d;
      active_q   <= active_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign busy        = busy_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign active_bank = active_q;
  assign done        = done_q;
  assign csum_err    = err_q;

endmodule

// File: tb/tb_wavetable_loader.sv
// Randomized frame-level bench for wavetable_loader against a bank/image reference model.
module tb_wavetable_loader;

  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [15:0] wr_data;
  logic        active_bank;
  logic        busy;
  logic        done;
  logic        csum_err;
  logic [10:0] rd_addr;
  logic [15:0] rd_data;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] samp      [1024];
  logic [15:0] model_mem [2048];
  logic [15:0] shadow    [2048];
  bit          model_bank;
  int          wr_count  = 0;
  int          active_wr = 0;

  always #5 clk = ~clk;

  wavetable_loader dut (
    .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .abort(abort), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .active_bank(active_bank), .busy(busy), .done(done), .csum_err(csum_err)
  );

  wavetable_bank_ram u_ram (
    .clk_i(clk), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data)
  );

  // Shadow of every RAM write, plus a tally of writes aimed at the bank being read.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      shadow[wr_addr] = wr_data;
      wr_count++;
      if (wr_addr[10] == active_bank) active_wr++;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_wr_en", wr_en, 0);
    check_eq("rst_wr_addr", wr_addr, 0);
    check_eq("rst_wr_data", wr_data, 0);
    check_eq("rst_active_bank", active_bank, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_csum_err", csum_err, 0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_pct);
    int waited;
    if (int'($urandom_range(99)) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    in_byte  = b;
    in_valid = 1'b1;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    if (waited >= 8) check_eq("ready_timeout", 1, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic verify_image(input string tag);
    int diffs = 0;
    for (int a = 0; a < 2048; a++) if (shadow[a] !== model_mem[a]) diffs++;
    check_eq({tag, "_ram_image"}, diffs, 0);
    check_eq({tag, "_active_bank_writes"}, active_wr, 0);
  endtask

  task automatic send_frame(input bit ramp, input bit bad_csum, input int abort_at,
                            input int reset_at, input bit abort_commit, input int gap_pct,
                            input bit junk);
    logic [7:0] x;
    int base, wr0;
    bit good;
    for (int i = 0; i < 1024; i++) samp[i] = ramp ? 16'(i * 3) : 16'($urandom);
    base = model_bank ? 0 : 1024;
    wr0  = wr_count;
    if (junk) begin
      send_byte(8'h00, gap_pct);
      send_byte(8'h5A, gap_pct);
    end
    send_byte(SYNC, gap_pct);
    x = 8'h00;
    for (int i = 0; i < 1024; i++) begin
      if (i == reset_at) begin
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check_reset_outputs();
        @(posedge clk); #1;
        reset = 1'b0;
        model_bank = 1'b0;
        return;
      end
      send_byte(samp[i][7:0], gap_pct);
      x ^= samp[i][7:0];
      if (i == abort_at) begin
        in_byte  = samp[i][15:8];
        in_valid = 1'b1;
        abort    = 1'b1;
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_in_ready", in_ready, 1);
        check_eq("abort_write_count", wr_count - wr0, i);
        repeat (3) @(posedge clk);
        #1;
        check_eq("abort_bank", active_bank, model_bank);
        check_eq("abort_err", csum_err, 0);
        return;
      end
      send_byte(samp[i][15:8], gap_pct);
      x ^= samp[i][15:8];
      model_mem[base + i] = samp[i];
    end
    if (bad_csum) x ^= 8'h01;
    send_byte(x, gap_pct);
    check_eq("commit_in_ready", in_ready, 0);
    check_eq("commit_busy", busy, 1);
    check_eq("write_count", wr_count - wr0, 1024);
    if (abort_commit) begin
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check_eq("abort_commit_done", done, 0);
      check_eq("abort_commit_err", csum_err, 0);
      check_eq("abort_commit_bank", active_bank, model_bank);
      check_eq("abort_commit_busy", busy, 0);
      return;
    end
    good = !bad_csum;
    @(posedge clk); #1;
    check_eq("done_pulse", done, good);
    check_eq("csum_err_pulse", csum_err, !good);
    if (good) model_bank = ~model_bank;
    check_eq("bank_after_commit", active_bank, model_bank);
    check_eq("ready_after_commit", in_ready, 1);
    check_eq("idle_after_commit", busy, 0);
    @(posedge clk); #1;
    check_eq("done_one_cycle", done, 0);
    check_eq("err_one_cycle", csum_err, 0);
  endtask

  initial begin
    reset    = 1'b1;
    in_byte  = 8'h00;
    in_valid = 1'b0;
    abort    = 1'b0;
    rd_addr  = '0;
    model_bank = 1'b0;
    for (int a = 0; a < 2048; a++) begin
      shadow[a]    = '0;
      model_mem[a] = '0;
    end
    #3;
    check_reset_outputs();
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;

    send_frame(1, 0, -1, 100, 0, 0, 0);
    verify_image("reset_mid_frame");
    send_frame(1, 0, -1, -1, 0, 0, 0);
    verify_image("ramp_good");
    send_frame(1, 1, -1, -1, 0, 0, 0);
    verify_image("ramp_bad_csum");
    send_frame(0, 0, -1, -1, 0, 0, 0);
    verify_image("rand_good");
    send_frame(1, 0, -1, -1, 0, 30, 1);
    verify_image("ramp_gaps_junk");
    send_frame(0, 0, 500, -1, 0, 0, 0);
    verify_image("abort_500");
    send_frame(0, 0, -1, -1, 0, 30, 0);
    verify_image("rand_gaps");
    send_frame(1, 0, -1, -1, 1, 0, 0);
    verify_image("abort_commit");
    send_frame(0, 0, -1, -1, 0, 0, 1);
    verify_image("rand_final");

    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = int'($urandom_range(1023));
      rd_addr = {model_bank, 10'(idx)};
      @(posedge clk); #1;
      check_eq("ram_read_active", rd_data, model_mem[{model_bank, 10'(idx)}]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
